display_source_scheduler: RTL and testbench
===========================================

// Module: display_source_scheduler
// PURPOSE
//  Time-shares the 8-digit seven-segment display between N_REQ requesters (result, operand entry, status, ...).
//  Round-robin arbitration with a guaranteed minimum dwell per grant; a button pulse skips to the next requester early.
//  Output word/blank mask feed the digit-scan driver, 4 bits per digit, digit 0 = bits [3:0].
// PARAMETERS
//  N_REQ      4        number of requesters (2..8)
//  DWELL_CYC  50000000 minimum cycles a grant is held before rotation (>=2)
// PORTS
//  clk_g       in   1          single clock; all logic on posedge
//  rst         in   1          synchronous, active-high reset
//  req         in   N_REQ      level request per source; bit i = source i
//  req_data    in   32*N_REQ   source i word at [32*i+31:32*i]
//  button      in   1          single-cycle advance pulse (debounced upstream)
//  grant       out  N_REQ      one-hot granted source, 0 when idle
//  disp_word   out  32         hex nibbles to display
//  disp_blank  out  8          1 = digit i dark
//  busy        out  1          1 while a source is granted
// BEHAVIOUR
//  - All outputs registered. Reset (synchronous, rst=1 at posedge): state IDLE, grant=0, disp_word=0,
//    disp_blank=8'hFF, busy=0, rr_ptr=N_REQ-1 (so req[0] wins first), dwell counter=0. rst overrides all inputs.
//  - States: IDLE, SHOW.
//  - IDLE: on edge where |req=1 -> SHOW; grant=first requesting index after rr_ptr (circular); rr_ptr<=that index;
//    disp_word<=its data; busy=1; dwell counter loaded DWELL_CYC-1. Latency req->grant/disp_word: 1 cycle.
//    button ignored in IDLE.
//  - SHOW, per edge:
//    * granted req high: disp_word<=granted source data (tracks live). Granted req low: disp_word holds (frozen).
//    * counter>0: decrement; grant unchanged regardless of req changes (dwell guaranteed).
//    * counter==0 (expiry): search circularly after rr_ptr over req.
//      other source requesting -> grant it, reload counter, load its data same edge.
//      only current source requesting -> keep grant, reload counter.
//      none requesting -> IDLE, grant=0, busy=0, disp_word=0, disp_blank=8'hFF.
//    * button=1 in SHOW: treated as immediate expiry but only rotates if another source requests;
//      otherwise ignored (counter continues). button coincident with expiry -> exactly one rotation.
//  - Grant lasts exactly DWELL_CYC cycles when others pending and no button.
//  - Counter width $clog2(DWELL_CYC); no wrap: reload always precedes underflow.
//  - In SHOW without the optional feature: disp_blank=8'h00.
//  - Reset mid-SHOW: next cycle all reset values; pending reqs regranted starting at req[0].
// CONFIGURATION
//  DISP_LZB_EN defined: leading-zero blanking in SHOW -- disp_blank bit i=1 when nibble i and all higher
//    nibbles are 0; bit 0 never blanked (word 0 shows a single "0"). Blank mask registered with disp_word,
//    same cycle, follows disp_word when tracking/frozen.
//  DISP_LZB_EN undefined: disp_blank=8'h00 in SHOW, 8'hFF in IDLE; no zero-detect logic synthesized.
// TESTING (bench: N_REQ=4, DWELL_CYC=4)
//  1 rst=1 two cycles, req=4'b1111 -> grant=0, disp_word=0, disp_blank=FF, busy=0 while rst; first edge after
//    release grant=0001, disp_word=req_data[31:0].
//  2 req=4'b0101 held -> grant 0001 for 4 cycles, 0100 for 4, 0001 for 4 ...; never 0010/1000.
//  3 req=4'b0010 only, data 32'h1234_5678; drop req after 1 cycle -> grant 0010 held 4 cycles, disp_word stays
//    32'h1234_5678, then IDLE, grant=0, disp_blank=FF.
//  4 req=4'b0011, button pulse 1 cycle after grant 0001 -> grant 0010 next edge, counter reloaded (held 4 cycles);
//    button with req=4'b0001 only -> no change.
//  5 DISP_LZB_EN: data 32'h0000_00A0 -> disp_blank=8'hFC; data 0 -> 8'hFE; data 32'h8000_0000 -> 8'h00.
//    Without macro: disp_blank=8'h00 for all three.
//  6 rst pulse during SHOW at grant 0100 with req=4'b1100 -> reset values next cycle, then grant 0100 (first
//    requester after rr_ptr=3 wraps to 0..: index 2), disp_word = source 2 data.

Source files
------------

// File: rtl/display_source_scheduler.sv
// Round-robin time-sharing of the 8-digit display between N_REQ sources, with minimum dwell and button skip.
// Optional build macro DISP_LZB_EN enables leading-zero blanking of the displayed word.
module display_source_scheduler #(
   parameter int N_REQ     = 4,
   parameter int DWELL_CYC = 50000000
) (
   input  logic                  clk_g,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req,
   input  logic [32*N_REQ-1:0]   req_data,
   input  logic                  button,
   output logic [N_REQ-1:0]      grant,
   output logic [31:0]           disp_word,
   output logic [7:0]            disp_blank,
   output logic                  busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(DWELL_CYC);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL_CYC - 1);
   localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(N_REQ - 1);
   localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHOW = 1'b1} state_t;

   state_t             state_r, state_nxt_s;
   logic [PTR_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
   logic [CNT_W-1:0]   cnt_r, cnt_nxt_s;
   logic [N_REQ-1:0]   grant_r, grant_nxt_s;
   logic [31:0]        word_r, word_nxt_s;
   logic [7:0]         blank_r, blank_nxt_s;
   logic               busy_r, busy_nxt_s;
   logic [PTR_W:0]     srch_s;
   logic               found_s, other_s, expired_s;
   logic [PTR_W-1:0]   idx_s;

   // First requesting index strictly after ptr, wrapping; ptr itself is checked last.
   function automatic logic [PTR_W:0] find_next(input logic [N_REQ-1:0] r, input logic [PTR_W-1:0] ptr);
      logic             found;
      logic [PTR_W-1:0] idx;
      int               j;
      found = 1'b0;
      idx   = ptr;
      for (int k = 1; k <= N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!found && r[j]) begin
            found = 1'b1;
            idx   = PTR_W'(j);
         end
      end
      return {found, idx};
   endfunction

`ifdef DISP_LZB_EN
   // Digit i dark when it and every higher digit are zero; digit 0 always lit.
   function automatic logic [7:0] lzb_mask(input logic [31:0] w);
      logic [7:0] m;
      logic       zero_above;
      m          = 8'h00;
      zero_above = 1'b1;
      for (int i = 7; i >= 1; i--) begin
         zero_above = zero_above & (w[4*i +: 4] == 4'h0);
         m[i]       = zero_above;
      end
      return m;
   endfunction
`endif

   assign srch_s    = find_next(req, rr_ptr_r);
   assign found_s   = srch_s[PTR_W];
   assign idx_s     = srch_s[PTR_W-1:0];
   assign other_s   = found_s && (idx_s != rr_ptr_r);
   assign expired_s = (cnt_r == {CNT_W{1'b0}});

   // State and registered outputs
   always_ff @(posedge clk_g) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         rr_ptr_r <= PTR_RST;
         cnt_r    <= {CNT_W{1'b0}};
         grant_r  <= {N_REQ{1'b0}};
         word_r   <= 32'h0000_0000;
         blank_r  <= 8'hFF;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         rr_ptr_r <= rr_ptr_nxt_s;
         cnt_r    <= cnt_nxt_s;
         grant_r  <= grant_nxt_s;
         word_r   <= word_nxt_s;
         blank_r  <= blank_nxt_s;
         busy_r   <= busy_nxt_s;
      end
   end

   // Next-state: leave SHOW only on expiry with nobody requesting
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) state_nxt_s = ST_SHOW;
            else         state_nxt_s = ST_IDLE;
         end
         ST_SHOW: begin
            if (expired_s && !found_s) state_nxt_s = ST_IDLE;
            else                       state_nxt_s = ST_SHOW;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values of pointer, dwell counter and display outputs
   always_comb begin
      rr_ptr_nxt_s = rr_ptr_r;
      cnt_nxt_s    = cnt_r;
      grant_nxt_s  = grant_r;
      word_nxt_s   = word_r;
      busy_nxt_s   = busy_r;
      case (state_r)
         ST_IDLE: begin
            if (found_s) begin
               rr_ptr_nxt_s = idx_s;
               cnt_nxt_s    = CNT_LOAD;
               grant_nxt_s  = ONE_HOT0 << idx_s;
               word_nxt_s   = req_data[32*int'(idx_s) +: 32];
               busy_nxt_s   = 1'b1;
            end else begin
               grant_nxt_s  = {N_REQ{1'b0}};
               word_nxt_s   = 32'h0000_0000;
               busy_nxt_s   = 1'b0;
            end
         end
         ST_SHOW: begin
            if (other_s && (expired_s || button)) begin
               rr_ptr_nxt_s = idx_s;
               cnt_nxt_s    = CNT_LOAD;
               grant_nxt_s  = ONE_HOT0 << idx_s;
               word_nxt_s   = req_data[32*int'(idx_s) +: 32];
            end else if (expired_s && found_s) begin
               cnt_nxt_s    = CNT_LOAD;
               word_nxt_s   = req_data[32*int'(rr_ptr_r) +: 32];
            end else if (expired_s) begin
               cnt_nxt_s    = {CNT_W{1'b0}};
               grant_nxt_s  = {N_REQ{1'b0}};
               word_nxt_s   = 32'h0000_0000;
               busy_nxt_s   = 1'b0;
            end else begin
               cnt_nxt_s    = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
               if (req[rr_ptr_r]) word_nxt_s = req_data[32*int'(rr_ptr_r) +: 32];
               else               word_nxt_s = word_r;
            end
         end
         default: begin
            grant_nxt_s = {N_REQ{1'b0}};
            word_nxt_s  = 32'h0000_0000;
            busy_nxt_s  = 1'b0;
         end
      endcase
`ifdef DISP_LZB_EN
      if (state_nxt_s == ST_SHOW) blank_nxt_s = lzb_mask(word_nxt_s);
      else                        blank_nxt_s = 8'hFF;
`else
      if (state_nxt_s == ST_SHOW) blank_nxt_s = 8'h00;
      else                        blank_nxt_s = 8'hFF;
`endif
   end

   assign grant      = grant_r;
   assign disp_word  = word_r;
   assign disp_blank = blank_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed self-checking bench for display_source_scheduler (N_REQ=4, DWELL_CYC=4).
module tb_display_source_scheduler;

   logic          clk_g = 1'b0;
   logic          rst;
   logic [3:0]    req;
   logic [127:0]  req_data;
   logic          button;
   logic [3:0]    grant;
   logic [31:0]   disp_word;
   logic [7:0]    disp_blank;
   logic          busy;
   logic [31:0]   d [4];
   int            checks_n = 0;
   int            fail_n   = 0;
   logic [3:0]    exp_g;
   logic [7:0]    blank_show;

   assign req_data = {d[3], d[2], d[1], d[0]};

   always #5 clk_g = ~clk_g;

   display_source_scheduler #(.N_REQ(4), .DWELL_CYC(4)) dut (
      .clk_g(clk_g), .rst(rst), .req(req), .req_data(req_data), .button(button),
      .grant(grant), .disp_word(disp_word), .disp_blank(disp_blank), .busy(busy)
   );

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks_n++;
      if (obs !== exp) begin
         fail_n++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_g);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000; button = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check_value({tag, "_grant"}, {28'h0, grant}, 32'h0);
      check_value({tag, "_word"},  disp_word, 32'h0);
      check_value({tag, "_blank"}, {24'h0, disp_blank}, 32'h0000_00FF);
      check_value({tag, "_busy"},  {31'h0, busy}, 32'h0);
   endtask

   initial begin
      d[0] = 32'h1111_0000; d[1] = 32'h1234_5678; d[2] = 32'h2222_0002; d[3] = 32'h3333_0003;
      rst = 1'b1; req = 4'b0000; button = 1'b0;

      // 1: reset holds everything idle even with all requests up
      req = 4'b1111;
      step(); check_idle("rst_a");
      step(); check_idle("rst_b");
      rst = 1'b0;
      step();
      check_value("rel_grant", {28'h0, grant}, 32'h1);
      check_value("rel_word",  disp_word, 32'h1111_0000);
      check_value("rel_busy",  {31'h0, busy}, 32'h1);
      check_value("rel_blank", {24'h0, disp_blank}, 32'h0);

      // 2: two requesters alternate every 4 cycles
      do_reset();
      req = 4'b0101;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_g = (((i / 4) % 2) == 1) ? 4'b0100 : 4'b0001;
         check_value($sformatf("rr_%0d", i), {28'h0, grant}, {28'h0, exp_g});
      end

      // 3: single requester drops out; word freezes, then idle after dwell
      do_reset();
      req = 4'b0010;
      step();
      check_value("drop_grant0", {28'h0, grant}, 32'h2);
      check_value("drop_word0",  disp_word, 32'h1234_5678);
      req = 4'b0000; d[1] = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         step();
         check_value($sformatf("drop_grant_%0d", i), {28'h0, grant}, 32'h2);
         check_value($sformatf("drop_word_%0d", i), disp_word, 32'h1234_5678);
      end
      step();
      check_idle("drop_idle");
      d[1] = 32'h1234_5678;

      // 4: button skips ahead when another source waits, ignored otherwise
      do_reset();
      req = 4'b0011;
      step();
      check_value("btn_g0", {28'h0, grant}, 32'h1);
      button = 1'b1;
      step();
      button = 1'b0;
      check_value("btn_g1",    {28'h0, grant}, 32'h2);
      check_value("btn_word1", disp_word, 32'h1234_5678);
      for (int i = 0; i < 3; i++) begin
         step();
         check_value($sformatf("btn_hold_%0d", i), {28'h0, grant}, 32'h2);
      end
      step();
      check_value("btn_rot", {28'h0, grant}, 32'h1);
      req = 4'b0001;
      button = 1'b1;
      step();
      button = 1'b0;
      check_value("btn_lone", {28'h0, grant}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_value($sformatf("btn_lone_%0d", i), {28'h0, grant}, 32'h1);
      end

      // 5: blank mask follows the tracked word
      do_reset();
      req = 4'b0001;
      d[0] = 32'h0000_00A0;
      step();
`ifdef DISP_LZB_EN
      blank_show = 8'hFC;
`else
      blank_show = 8'h00;
`endif
      check_value("lzb_a0_word", disp_word, 32'h0000_00A0);
      check_value("lzb_a0", {24'h0, disp_blank}, {24'h0, blank_show});
      d[0] = 32'h0000_0000;
      step();
`ifdef DISP_LZB_EN
      blank_show = 8'hFE;
`else
      blank_show = 8'h00;
`endif
      check_value("lzb_zero", {24'h0, disp_blank}, {24'h0, blank_show});
      d[0] = 32'h8000_0000;
      step();
      check_value("lzb_top_word", disp_word, 32'h8000_0000);
      check_value("lzb_top", {24'h0, disp_blank}, 32'h0);
      d[0] = 32'h1111_0000;

      // 6: reset during SHOW restarts arbitration from the reset pointer
      do_reset();
      req = 4'b1100;
      step();
      check_value("mid_g0", {28'h0, grant}, 32'h4);
      rst = 1'b1;
      step();
      check_idle("mid_rst");
      rst = 1'b0;
      step();
      check_value("mid_g1",    {28'h0, grant}, 32'h4);
      check_value("mid_word1", disp_word, 32'h2222_0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
      $finish;
   end

endmodule
